chip8_fb_arbiter: RTL and testbench

Arbiter and sequencer for the single-port Chip-8 framebuffer RAM (64x32 monochrome, 8 pixels per byte, 256 bytes). It shares the RAM between three clients: video scanout reads, blitter sprite XOR read-modify-write with collision detect, and a screen-clear (CLS) engine. It sits between the blitter, the VGA scanout and the framebuffer block RAM in the MiST build, all in the core clock domain.

---
 rtl/chip8_fb_arbiter_if.sv | 31 +++
 rtl/chip8_fb_arbiter.sv | 128 ++++++++++++
 tb/tb_chip8_fb_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_fb_arbiter_if.sv
// Client handshakes and RAM port shared between the Chip-8 framebuffer arbiter and its environment.
// The arbiter takes the slave view; the clients plus the RAM model take the master view.
interface chip8_fb_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [7:0]        vid_data;
    logic              blt_req;
    logic [ADDR_W-1:0] blt_addr;
    logic [7:0]        blt_data;
    logic              blt_ack;
    logic              blt_collision;
    logic              clr_req;
    logic              clr_busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  vid_req, vid_addr, blt_req, blt_addr, blt_data, clr_req, mem_rdata,
        output vid_ack, vid_data, blt_ack, blt_collision, clr_busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, blt_req, blt_addr, blt_data, clr_req, mem_rdata,
        input  vid_ack, vid_data, blt_ack, blt_collision, clr_busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/chip8_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads, blitter XOR read-modify-write and screen clear.
// Grants are evaluated only in IDLE with priority video, clear, blitter; nothing is preempted.
module chip8_fb_arbiter #(
    parameter int ADDR_W = 8
) (
    input logic               clk,
    input logic               reset,
    chip8_fb_arbiter_if.slave fb
);

    typedef enum logic [2:0] {IDLE, VID_RD, VID_CAP, BLT_RD, BLT_MOD, BLT_WR, CLR} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [7:0]        data_q;
    logic [7:0]        new_q;
    logic              flag_q;
    logic              vid_ack_q;
    logic [7:0]        vid_data_q;
    logic              blt_ack_q;
    logic              blt_collision_q;
    logic              clr_pending_q;

    logic              grant_vid;
    logic              grant_clr;
    logic              grant_blt;

    // A requester whose ack is still high is completing its handshake and must not be re-granted.
    assign grant_vid = (state_q == IDLE) && fb.vid_req && !vid_ack_q;
    assign grant_clr = (state_q == IDLE) && !grant_vid && clr_pending_q;
    assign grant_blt = (state_q == IDLE) && !grant_vid && !clr_pending_q && !fb.clr_req
                       && fb.blt_req && !blt_ack_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            vid_ack_q       <= 1'b0;
            vid_data_q      <= 8'h00;
            blt_ack_q       <= 1'b0;
            blt_collision_q <= 1'b0;
            clr_cnt_q       <= '0;
            clr_pending_q   <= 1'b0;
        end else begin
            vid_ack_q <= 1'b0;
            blt_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vid)      state_q <= VID_RD;
                    else if (grant_clr) state_q <= CLR;
                    else if (grant_blt) state_q <= BLT_RD;
                end
                VID_RD:  state_q <= VID_CAP;
                VID_CAP: begin
                    vid_data_q <= fb.mem_rdata;
                    vid_ack_q  <= 1'b1;
                    state_q    <= IDLE;
                end
                BLT_RD:  state_q <= BLT_MOD;
                BLT_MOD: state_q <= BLT_WR;
                BLT_WR: begin
                    blt_ack_q       <= 1'b1;
                    blt_collision_q <= flag_q;
                    state_q         <= IDLE;
                end
                CLR: begin
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (&clr_cnt_q) clr_pending_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A new clear request restarts the sweep and overrides the end-of-sweep release.
            if (fb.clr_req) begin
                clr_pending_q <= 1'b1;
                clr_cnt_q     <= '0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; every state that reads them is entered through a grant that reloads them.
    always_ff @(posedge clk) begin
        if (grant_vid) begin
            addr_q <= fb.vid_addr;
        end else if (grant_blt) begin
            addr_q <= fb.blt_addr;
            data_q <= fb.blt_data;
        end
        if (state_q == BLT_MOD) begin
            new_q  <= fb.mem_rdata ^ data_q;
            flag_q <= |(fb.mem_rdata & data_q);
        end
    end

    logic [ADDR_W-1:0] mem_addr_dec;
    logic              mem_we_dec;
    logic [7:0]        mem_wdata_dec;

    // NOTE: every decoded output gets a default before the case so no path infers a latch.
    always_comb begin
        mem_addr_dec  = fb.vid_addr;
        mem_we_dec    = 1'b0;
        mem_wdata_dec = 8'h00;
        case (state_q)
            VID_RD, BLT_RD: mem_addr_dec = addr_q;
            BLT_WR: begin
                mem_addr_dec  = addr_q;
                mem_we_dec    = 1'b1;
                mem_wdata_dec = new_q;
            end
            CLR: begin
                mem_addr_dec = clr_cnt_q;
                mem_we_dec   = 1'b1;
            end
            default: ;
        endcase
    end

    assign fb.mem_addr      = mem_addr_dec;
    assign fb.mem_we        = mem_we_dec & ~reset;
    assign fb.mem_wdata     = mem_wdata_dec;
    assign fb.vid_ack       = vid_ack_q;
    assign fb.vid_data      = vid_data_q;
    assign fb.blt_ack       = blt_ack_q;
    assign fb.blt_collision = blt_collision_q;
    assign fb.clr_busy      = clr_pending_q;

endmodule

// File: tb/tb_chip8_fb_arbiter.sv
// Self-checking bench for chip8_fb_arbiter: behavioural synchronous RAM, directed vector table,
// hand-written multi-cycle sequences and random transactions against a transaction-level memory model.
module tb_chip8_fb_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chip8_fb_arbiter_if #(.ADDR_W(8)) bus ();
    chip8_fb_arbiter #(.ADDR_W(8)) dut (.clk(clk), .reset(reset), .fb(bus));

    // Framebuffer RAM: one-cycle read latency, read-before-write, with a bench preload port.
    logic [7:0] ram [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    // Latency n counts edges from the one that samples the request (n=1).
    task automatic run_vid(input logic [7:0] a, output logic [7:0] d, output int lat);
        bus.vid_addr = a;
        bus.vid_req  = 1'b1;
        lat = 0;
        d   = 8'h00;
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (bus.vid_ack) begin
                lat = n;
                d   = bus.vid_data;
                break;
            end
        end
        bus.vid_req = 1'b0;
        tick();
        check("vid_ack_single_pulse", 32'(bus.vid_ack), 32'd0);
    endtask

    task automatic run_blt(input logic [7:0] a, input logic [7:0] d, output logic coll, output int lat);
        bus.blt_addr = a;
        bus.blt_data = d;
        bus.blt_req  = 1'b1;
        lat  = 0;
        coll = 1'b0;
        for (int n = 1; n <= 32; n++) begin
            tick();
            if (bus.blt_ack) begin
                lat  = n;
                coll = bus.blt_collision;
                break;
            end
        end
        bus.blt_req = 1'b0;
        tick();
        check("blt_ack_single_pulse", 32'(bus.blt_ack), 32'd0);
    endtask

    typedef struct {
        logic       is_blt;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] pre;
        logic [7:0] exp_byte;
        logic       exp_coll;
    } vec_t;

    localparam int NV     = 8;
    localparam int NRAND  = 60;
    localparam int NREADS = 264;

    vec_t       vecs [NV];
    logic [7:0] ref_mem [256];
    logic [7:0] rd;
    logic [7:0] a_cur;
    logic [7:0] d_cur;
    logic [7:0] exp_b;
    logic       coll;
    logic       exp_c;
    int         lat;
    int         vlat;
    int         blat;
    int         busy_cycles;
    int         k;
    int         nonzero;
    int         stray_acks;
    logic       got;
    logic       raised;
    logic       ack_busy;

    initial begin
        reset        = 1'b1;
        bus.vid_req  = 1'b0;
        bus.vid_addr = 8'h00;
        bus.blt_req  = 1'b0;
        bus.blt_addr = 8'h00;
        bus.blt_data = 8'h00;
        bus.clr_req  = 1'b0;
        pre_we       = 1'b0;
        pre_addr     = 8'h00;
        pre_data     = 8'h00;
        repeat (3) tick();

        check("rst_vid_ack",       32'(bus.vid_ack),       32'd0);
        check("rst_blt_ack",       32'(bus.blt_ack),       32'd0);
        check("rst_clr_busy",      32'(bus.clr_busy),      32'd0);
        check("rst_vid_data",      32'(bus.vid_data),      32'd0);
        check("rst_blt_collision", 32'(bus.blt_collision), 32'd0);
        check("rst_mem_we",        32'(bus.mem_we),        32'd0);
        reset = 1'b0;
        tick();

        // Directed vectors: {op, addr, sprite byte, RAM preload, expected byte, expected collision}.
        vecs[0] = '{1'b0, 8'h05, 8'h00, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 8'h10, 8'h3C, 8'h0F, 8'h33, 1'b1};
        vecs[2] = '{1'b1, 8'h10, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 8'h00, 8'h5A, 8'h5A, 1'b0};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h81, 8'h81, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0};
        vecs[7] = '{1'b1, 8'h80, 8'h01, 8'hFE, 8'hFF, 1'b0};
        for (int i = 0; i < NV; i++) begin
            preload(vecs[i].addr, vecs[i].pre);
            if (vecs[i].is_blt) begin
                run_blt(vecs[i].addr, vecs[i].data, coll, lat);
                check($sformatf("vec%0d_blt_latency", i), 32'(lat), 32'd4);
                check($sformatf("vec%0d_collision", i), 32'(coll), 32'(vecs[i].exp_coll));
                check($sformatf("vec%0d_ram", i), 32'(ram[vecs[i].addr]), 32'(vecs[i].exp_byte));
            end else begin
                run_vid(vecs[i].addr, rd, lat);
                check($sformatf("vec%0d_vid_latency", i), 32'(lat), 32'd3);
                check($sformatf("vec%0d_vid_data", i), 32'(rd), 32'(vecs[i].exp_byte));
            end
        end

        // Video and blitter raised together: video first, blitter granted in the ack cycle.
        preload(8'h31, 8'h77);
        preload(8'h30, 8'h11);
        bus.vid_addr = 8'h31;
        bus.vid_req  = 1'b1;
        bus.blt_addr = 8'h30;
        bus.blt_data = 8'h10;
        bus.blt_req  = 1'b1;
        vlat = 0;
        blat = 0;
        rd   = 8'h00;
        coll = 1'b0;
        for (int n = 1; n <= 40 && (vlat == 0 || blat == 0); n++) begin
            tick();
            if (bus.vid_ack && vlat == 0) begin
                vlat = n;
                rd   = bus.vid_data;
                bus.vid_req = 1'b0;
            end
            if (bus.blt_ack && blat == 0) begin
                blat = n;
                coll = bus.blt_collision;
                bus.blt_req = 1'b0;
            end
        end
        bus.vid_req = 1'b0;
        bus.blt_req = 1'b0;
        tick();
        check("both_vid_latency",  32'(vlat), 32'd3);
        check("both_blt_latency",  32'(blat), 32'd7);
        check("both_vid_data",     32'(rd),   32'h77);
        check("both_blt_collision", 32'(coll), 32'd1);
        check("both_blt_ram",      32'(ram[8'h30]), 32'h01);

        // Random single transactions against a byte-array model of the framebuffer.
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom);
            preload(8'(i), ref_mem[i]);
        end
        for (int i = 0; i < NRAND; i++) begin
            a_cur = 8'($urandom);
            d_cur = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                run_vid(a_cur, rd, lat);
                check($sformatf("rnd%0d_vid_latency", i), 32'(lat), 32'd3);
                check($sformatf("rnd%0d_vid_data", i), 32'(rd), 32'(ref_mem[a_cur]));
            end else begin
                exp_c = |(ref_mem[a_cur] & d_cur);
                ref_mem[a_cur] = ref_mem[a_cur] ^ d_cur;
                run_blt(a_cur, d_cur, coll, lat);
                check($sformatf("rnd%0d_blt_latency", i), 32'(lat), 32'd4);
                check($sformatf("rnd%0d_collision", i), 32'(coll), 32'(exp_c));
                check($sformatf("rnd%0d_ram", i), 32'(ram[a_cur]), 32'(ref_mem[a_cur]));
            end
        end

        // Clear on a full screen, with a blitter request raised mid-sweep.
        for (int i = 0; i < 256; i++) preload(8'(i), 8'hFF);
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        check("clr_busy_rise", 32'(bus.clr_busy), 32'd1);
        busy_cycles = 0;
        got      = 1'b0;
        raised   = 1'b0;
        ack_busy = 1'b0;
        coll     = 1'b1;
        for (int n = 0; n < 2000 && !got; n++) begin
            if (bus.clr_busy) busy_cycles++;
            if (busy_cycles == 100 && !raised) begin
                bus.blt_addr = 8'h40;
                bus.blt_data = 8'h5A;
                bus.blt_req  = 1'b1;
                raised = 1'b1;
            end
            tick();
            if (bus.blt_ack) begin
                got      = 1'b1;
                ack_busy = bus.clr_busy;
                coll     = bus.blt_collision;
                bus.blt_req = 1'b0;
            end
        end
        bus.blt_req = 1'b0;
        tick();
        check("clr_busy_cycles",     32'(busy_cycles), 32'd512);
        check("clr_blt_acked",       32'(got),         32'd1);
        check("clr_blt_ack_waited",  32'(ack_busy),    32'd0);
        check("clr_blt_collision",   32'(coll),        32'd0);
        check("clr_blt_ram",         32'(ram[8'h40]),  32'h5A);
        nonzero = 0;
        for (int i = 0; i < 256; i++) if (i != 8'h40 && ram[i] != 8'h00) nonzero++;
        check("clr_bytes_left_set", 32'(nonzero), 32'd0);

        // Continuous video during a clear: read k sees addresses below k already cleared.
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'($urandom_range(1, 255));
            preload(8'(i), ref_mem[i]);
        end
        k     = 0;
        got   = 1'b0;
        a_cur = 8'($urandom);
        bus.vid_addr = a_cur;
        bus.vid_req  = 1'b1;
        bus.clr_req  = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        for (int n = 0; n < 4000 && !got; n++) begin
            if (bus.vid_ack) begin
                exp_b = (int'(a_cur) < k) ? 8'h00 : ref_mem[a_cur];
                check($sformatf("clrvid%0d_data", k), 32'(bus.vid_data), 32'(exp_b));
                k++;
                if (k == NREADS) begin
                    bus.vid_req = 1'b0;
                    got = 1'b1;
                end else begin
                    a_cur = 8'($urandom);
                    bus.vid_addr = a_cur;
                end
            end
            if (!got) tick();
        end
        bus.vid_req = 1'b0;
        tick();
        check("clrvid_reads_done", 32'(k), 32'(NREADS));
        check("clrvid_busy_fell",  32'(bus.clr_busy), 32'd0);
        nonzero = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != 8'h00) nonzero++;
        check("clrvid_all_cleared", 32'(nonzero), 32'd0);

        // Reset landing in BLT_WR: write suppressed, no ack, outputs cleared, fresh request works.
        preload(8'h51, 8'hC3);
        run_vid(8'h51, rd, lat);
        check("pre_rst_vid_data", 32'(rd), 32'hC3);
        preload(8'h52, 8'h01);
        run_blt(8'h52, 8'h01, coll, lat);
        check("pre_rst_collision", 32'(coll), 32'd1);
        preload(8'h50, 8'h00);
        bus.vid_addr = 8'h00;
        bus.blt_addr = 8'h50;
        bus.blt_data = 8'hFF;
        bus.blt_req  = 1'b1;
        repeat (3) tick();
        check("rst_wr_mem_we_before", 32'(bus.mem_we), 32'd1);
        reset       = 1'b1;
        bus.blt_req = 1'b0;
        #1;
        check("rst_wr_mem_we_gated", 32'(bus.mem_we), 32'd0);
        tick();
        reset = 1'b0;
        check("rst_wr_ram_untouched", 32'(ram[8'h50]),        32'h00);
        check("rst_wr_blt_ack",       32'(bus.blt_ack),       32'd0);
        check("rst_wr_vid_ack",       32'(bus.vid_ack),       32'd0);
        check("rst_wr_vid_data",      32'(bus.vid_data),      32'd0);
        check("rst_wr_collision",     32'(bus.blt_collision), 32'd0);
        check("rst_wr_clr_busy",      32'(bus.clr_busy),      32'd0);
        check("rst_wr_mem_we",        32'(bus.mem_we),        32'd0);
        check("rst_wr_mem_addr",      32'(bus.mem_addr),      32'd0);
        check("rst_wr_mem_wdata",     32'(bus.mem_wdata),     32'd0);
        stray_acks = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus.blt_ack) stray_acks++;
        end
        check("rst_wr_no_late_ack", 32'(stray_acks), 32'd0);
        run_blt(8'h50, 8'h0F, coll, lat);
        check("post_rst_blt_latency",   32'(lat),         32'd4);
        check("post_rst_blt_collision", 32'(coll),        32'd0);
        check("post_rst_blt_ram",       32'(ram[8'h50]),  32'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
